// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The controller takes the master view; the datapath (or a bench) takes the slave view.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             memready;
  logic             pcwrite;
  logic             pcwritecond;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, memready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal,
           state, instret
  );

  modport slave (
    output opcode, memready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal,
           state, instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multi-cycle MIPS datapath with a shared
// memory port, memready stretching, and a retired-instruction counter.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]       state_q;
  logic [3:0]       next_state;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             decode_ok;

  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;

  assign decode_ok = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_LW) ||
                     (bus.opcode == OP_SW)    || (bus.opcode == OP_BEQ) ||
                     (bus.opcode == OP_J)     || (bus.opcode == OP_ADDI);

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:  next_state = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     next_state = S_EXEC;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = bus.memready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // An instruction retires on its last cycle; a stalled store has not finished yet.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      S_MEMWR: retire = bus.memready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= next_state;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = bus.memready;
        pcwrite = bus.memready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
      default: ;
    endcase
  end

  // Reset suppresses every write strobe so an aborted instruction leaves no trace.
  assign bus.pcwrite     = pcwrite & ~reset;
  assign bus.pcwritecond = pcwritecond & ~reset;
  assign bus.memread     = memread & ~reset;
  assign bus.memwrite    = memwrite & ~reset;
  assign bus.irwrite     = irwrite & ~reset;
  assign bus.regwrite    = regwrite & ~reset;
  assign bus.illegal     = (state_q == S_DECODE) & ~decode_ok & ~reset;
  assign bus.iord        = iord;
  assign bus.memtoreg    = memtoreg;
  assign bus.regdst      = regdst;
  assign bus.alusrca     = alusrca;
  assign bus.alusrcb     = alusrcb;
  assign bus.aluop       = aluop;
  assign bus.pcsource    = pcsource;
  assign bus.state       = state_q;
  assign bus.instret     = count_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main control FSM for the multi-cycle MIPS datapath. It sequences the program counter, instruction/data memory, register file, sign-extend/ALU muxes and ALU through fetch, decode, execute, memory and writeback steps. Instruction and data memory share one port, and a memory-ready handshake can stretch any memory step. It also keeps a retired-instruction counter for the bench.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- opcode  in  6  instruction[31:26] from the instruction register
- memready  in  1  memory completes the current read or write this cycle
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load if ALU zero
- iord  out  1  memory address mux: 0=PC, 1=ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data: 0=ALUOut, 1=MDR
- regdst  out  1  destination register: 0=rt, 1=rd
- regwrite  out  1  register file write enable (registerfile regWflag)
- alusrca  out  1  ALU A: 0=PC, 1=reg A
- alusrcb  out  2  ALU B: 00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2
- aluop  out  2  00=add, 01=sub, 10=funct-decoded
- pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal  out  1  unknown opcode decoded this cycle
- state  out  4  current state (debug)
- instret  out  CNT_W  retired-instruction count

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 are unreachable; if entered, next state is FETCH.
- Outputs are decoded from `state` only; `illegal` additionally uses `opcode`. Any output not listed for a state is 0.
- FETCH: memread=1, alusrcb=01, aluop=00, pcsource=00. irwrite=pcwrite=memready. Stay while !memready; on memready go to DECODE.
- DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - anything else -> FETCH, with illegal=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: memread=1, iord=1. Stay until memready, then go to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR: memwrite=1, iord=1. Stay until memready, then go to FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10. Next RWB.
- RWB: regwrite=1, regdst=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. Next FETCH.
- JUMP: pcwrite=1, pcsource=10. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Next FETCH.
- instret increments by 1 on the final cycle of each instruction (the cycle whose next state is FETCH). Not counted: illegal DECODE, and the final cycle of MEMWR only counts when memready=1. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset, sampled at a rising edge: next state=FETCH and instret=0. While reset=1, all strobe outputs (pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite) are forced to 0 and illegal=0.
- Reset asserted mid-instruction aborts it with no writes in the reset cycle; the instruction is not counted.
- Latency with memready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2 cycles.
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes stay asserted and stable while stalled.
- opcode is sampled only in DECODE and MEMADR. The IR holds it stable from the FETCH completion edge onward.
- pcwrite and irwrite are high for exactly one cycle per fetch, namely the memready cycle.

## Test plan
- Reset then memready=1, opcode=000000: states 0,1,6,7,0. regwrite=1 with regdst=1 only in state 7. instret=1 after 4 cycles.
- lw (100011) with memready low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. memread and iord held through the stall. Total 7 cycles; instret +1.
- sw (101011), memready=1: states 0,1,2,5,0. memwrite=1 only in state 5. regwrite never 1.
- beq then j, memready=1: beq gives 0,1,8 with pcwritecond=1, aluop=01. j gives 0,1,9 with pcwrite=1, pcsource=10. instret=2 after 6 cycles.
- opcode=111111 -> illegal=1 in DECODE, back to FETCH, instret unchanged. Then assert reset during EXEC of an R-type -> no regwrite, state=0, instret=0.
- Preload instret to 2^32-1 via 2^32-1 addi instructions (or a forced counter in the bench), then run one more addi -> instret=0.
